// File: rtl/mem_rd_ctrl_if.sv
// Bundle of upstream, data-cache and downstream signals for the memory-read stage.
// The slave view belongs to the controller; the master view belongs to its surroundings.
interface mem_rd_ctrl_if #(
  parameter int TAGW = 8
);
  logic            i_v;
  logic            i_memRen;
  logic [31:0]     i_virt_addr;
  logic [31:0]     i_seg_lim;
  logic [1:0]      i_opSize;
  logic [TAGW-1:0] i_tag;
  logic            o_stall;

  logic            o_dc_req;
  logic [31:0]     o_dc_addr;
  logic            i_dc_ack;
  logic [31:0]     i_dc_data;

  logic            i_flush;
  logic            i_stall;
  logic            o_v;
  logic [31:0]     o_data;
  logic            o_fault;
  logic [TAGW-1:0] o_tag;

  modport slave (
    input  i_v, i_memRen, i_virt_addr, i_seg_lim, i_opSize, i_tag,
    input  i_dc_ack, i_dc_data, i_flush, i_stall,
    output o_stall, o_dc_req, o_dc_addr, o_v, o_data, o_fault, o_tag
  );

  modport master (
    output i_v, i_memRen, i_virt_addr, i_seg_lim, i_opSize, i_tag,
    output i_dc_ack, i_dc_data, i_flush, i_stall,
    input  o_stall, o_dc_req, o_dc_addr, o_v, o_data, o_fault, o_tag
  );
endinterface

// File: rtl/mem_rd_ctrl.sv
// Memory-read stage: segment-limit check, one or two aligned cache reads,
// and right-justified zero-extended result delivery with valid/stall handshakes.
module mem_rd_ctrl #(
  parameter int DW   = 32,
  parameter int TAGW = 8
) (
  input  logic          clk,
  input  logic          rst,
  mem_rd_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ0 = 2'd1,
    REQ1 = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [31:0]     addr_q, addr_d;
  logic [1:0]      size_q, size_d;
  logic [TAGW-1:0] tag_q, tag_d;
  logic [DW-1:0]   lo_q, lo_d;
  logic [DW-1:0]   hi_q, hi_d;
  logic            fault_q, fault_d;
  logic            kill_q, kill_d;

  logic [2:0]      nBytes;
  logic            split;
  logic            startFault;
  logic [31:0]     wordAddr;
  logic [31:0]     nextWordAddr;
  logic [2*DW-1:0] shiftedPair;
  logic [DW-1:0]   byteMask;
  logic [DW-1:0]   assembled;

  always_comb begin
    nBytes   = 3'd1;
    byteMask = {{(DW-8){1'b0}}, 8'hFF};
    case (size_q)
      2'b10: begin
        nBytes   = 3'd2;
        byteMask = {{(DW-16){1'b0}}, 16'hFFFF};
      end
      2'b11: begin
        nBytes   = 3'd4;
        byteMask = {DW{1'b1}};
      end
      default: begin
        nBytes   = 3'd1;
        byteMask = {{(DW-8){1'b0}}, 8'hFF};
      end
    endcase
  end

  // An access straddles a word boundary when its last byte lands past offset 3.
  assign split        = ({1'b0, addr_q[1:0]} + nBytes) > 3'd4;
  assign startFault   = bus.i_virt_addr > bus.i_seg_lim;
  assign wordAddr     = {addr_q[31:2], 2'b00};
  assign nextWordAddr = wordAddr + 32'd4;
  assign shiftedPair  = {hi_q, lo_q} >> {addr_q[1:0], 3'b000};
  assign assembled    = shiftedPair[DW-1:0] & byteMask;

  // Every output is forced to zero outside the state that gives it meaning.
  assign bus.o_stall   = (state_q != IDLE);
  assign bus.o_v       = (state_q == DONE);
  assign bus.o_dc_req  = (state_q == REQ0) || (state_q == REQ1);
  assign bus.o_dc_addr = (state_q == REQ0) ? wordAddr :
                         (state_q == REQ1) ? nextWordAddr : 32'd0;
  assign bus.o_data    = (state_q == DONE) ? assembled : {DW{1'b0}};
  assign bus.o_fault   = (state_q == DONE) && fault_q;
  assign bus.o_tag     = (state_q == DONE) ? tag_q : {TAGW{1'b0}};

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    size_d  = size_q;
    tag_d   = tag_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    fault_d = fault_q;
    kill_d  = kill_q;

    case (state_q)
      IDLE: begin
        kill_d = 1'b0;
        if (!bus.i_flush && bus.i_v) begin
          addr_d  = bus.i_virt_addr;
          size_d  = bus.i_opSize;
          tag_d   = bus.i_tag;
          lo_d    = {DW{1'b0}};
          hi_d    = {DW{1'b0}};
          fault_d = bus.i_memRen && startFault;
          if (bus.i_memRen && !startFault) begin
            state_d = REQ0;
          end else begin
            state_d = DONE;
          end
        end
      end

      REQ0: begin
        if (bus.i_flush) begin
          kill_d = 1'b1;
        end
        if (bus.i_dc_ack) begin
          lo_d = bus.i_dc_data;
          if (split) begin
            state_d = REQ1;
          end else if (kill_q || bus.i_flush) begin
            state_d = IDLE;
            kill_d  = 1'b0;
          end else begin
            state_d = DONE;
          end
        end
      end

      REQ1: begin
        if (bus.i_flush) begin
          kill_d = 1'b1;
        end
        if (bus.i_dc_ack) begin
          hi_d = bus.i_dc_data;
          if (kill_q || bus.i_flush) begin
            state_d = IDLE;
            kill_d  = 1'b0;
          end else begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        if (bus.i_flush || !bus.i_stall) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        kill_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= 32'd0;
      size_q  <= 2'd0;
      tag_q   <= {TAGW{1'b0}};
      lo_q    <= {DW{1'b0}};
      hi_q    <= {DW{1'b0}};
      fault_q <= 1'b0;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      tag_q   <= tag_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      fault_q <= fault_d;
      kill_q  <= kill_d;
    end
  end

endmodule

// File: tb/tb_mem_rd_ctrl.sv
// Directed bench for mem_rd_ctrl: a table of single-op vectors with immediate
// cache acks, then hand-written backpressure, flush and reset sequences.
module tb_mem_rd_ctrl;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mem_rd_ctrl_if #(.TAGW(8)) bus ();

  mem_rd_ctrl #(.DW(32), .TAGW(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] lim;
    logic [1:0]  size;
    logic        memRen;
    logic [7:0]  tag;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        expReq;
    logic        expSplit;
    logic [31:0] expA0;
    logic [31:0] expA1;
    logic [31:0] expData;
    logic        expFault;
  } vec_t;

  vec_t vecs [12];
  int compared   = 0;
  int mismatched = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idleInputs();
    bus.i_v         = 1'b0;
    bus.i_memRen    = 1'b0;
    bus.i_virt_addr = 32'd0;
    bus.i_seg_lim   = 32'd0;
    bus.i_opSize    = 2'b00;
    bus.i_tag       = 8'd0;
    bus.i_dc_ack    = 1'b0;
    bus.i_dc_data   = 32'd0;
    bus.i_flush     = 1'b0;
    bus.i_stall     = 1'b0;
  endtask

  task automatic checkAllZero(input string prefix);
    checkOutput({prefix, ".stall"},  {31'd0, bus.o_stall},  32'd0);
    checkOutput({prefix, ".v"},      {31'd0, bus.o_v},      32'd0);
    checkOutput({prefix, ".req"},    {31'd0, bus.o_dc_req}, 32'd0);
    checkOutput({prefix, ".dcaddr"}, bus.o_dc_addr,         32'd0);
    checkOutput({prefix, ".data"},   bus.o_data,            32'd0);
    checkOutput({prefix, ".fault"},  {31'd0, bus.o_fault},  32'd0);
    checkOutput({prefix, ".tag"},    {24'd0, bus.o_tag},    32'd0);
  endtask

  // Presents one memory-read op for a single cycle; returns at the negedge after acceptance.
  task automatic startOp(input logic [31:0] addr, input logic [1:0] size,
                         input logic [31:0] lim, input logic [7:0] tag);
    @(negedge clk);
    bus.i_v         = 1'b1;
    bus.i_memRen    = 1'b1;
    bus.i_virt_addr = addr;
    bus.i_opSize    = size;
    bus.i_seg_lim   = lim;
    bus.i_tag       = tag;
    @(negedge clk);
    bus.i_v = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    string p;
    p = $sformatf("vec%0d", idx);
    @(negedge clk);
    checkOutput({p, ".idleStall"}, {31'd0, bus.o_stall}, 32'd0);
    bus.i_v         = 1'b1;
    bus.i_memRen    = v.memRen;
    bus.i_virt_addr = v.addr;
    bus.i_seg_lim   = v.lim;
    bus.i_opSize    = v.size;
    bus.i_tag       = v.tag;
    @(negedge clk);
    bus.i_v = 1'b0;
    if (v.expReq) begin
      checkOutput({p, ".req0"},     {31'd0, bus.o_dc_req}, 32'd1);
      checkOutput({p, ".req0Addr"}, bus.o_dc_addr,         v.expA0);
      checkOutput({p, ".req0V"},    {31'd0, bus.o_v},      32'd0);
      bus.i_dc_ack  = 1'b1;
      bus.i_dc_data = v.lo;
      if (v.expSplit) begin
        @(negedge clk);
        checkOutput({p, ".req1"},     {31'd0, bus.o_dc_req}, 32'd1);
        checkOutput({p, ".req1Addr"}, bus.o_dc_addr,         v.expA1);
        bus.i_dc_data = v.hi;
      end
      @(negedge clk);
      bus.i_dc_ack  = 1'b0;
      bus.i_dc_data = 32'd0;
    end else begin
      checkOutput({p, ".noReq"}, {31'd0, bus.o_dc_req}, 32'd0);
    end
    checkOutput({p, ".doneV"},     {31'd0, bus.o_v},     32'd1);
    checkOutput({p, ".doneData"},  bus.o_data,           v.expData);
    checkOutput({p, ".doneFault"}, {31'd0, bus.o_fault}, {31'd0, v.expFault});
    checkOutput({p, ".doneTag"},   {24'd0, bus.o_tag},   {24'd0, v.tag});
    checkOutput({p, ".doneStall"}, {31'd0, bus.o_stall}, 32'd1);
    @(negedge clk);
    checkOutput({p, ".consumed"}, {31'd0, bus.o_v}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    //            addr          lim           sz     ren   tag    lo            hi            req   split a0            a1            data          fault
    vecs[0]  = '{32'h00001000, 32'h0000FFFF, 2'b11, 1'b1, 8'h11, 32'hDDCCBBAA, 32'h00000000, 1'b1, 1'b0, 32'h00001000, 32'h00000000, 32'hDDCCBBAA, 1'b0};
    vecs[1]  = '{32'h00001003, 32'h0000FFFF, 2'b11, 1'b1, 8'h12, 32'h44332211, 32'h88776655, 1'b1, 1'b1, 32'h00001000, 32'h00001004, 32'h77665544, 1'b0};
    vecs[2]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 2'b10, 1'b1, 8'h13, 32'hAA000000, 32'h000000BB, 1'b1, 1'b1, 32'hFFFFFFFC, 32'h00000000, 32'h0000BBAA, 1'b0};
    vecs[3]  = '{32'h00002001, 32'h00002000, 2'b11, 1'b1, 8'h5A, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 32'h00000000, 32'h00000000, 32'h00000000, 1'b1};
    vecs[4]  = '{32'h00003002, 32'h0000FFFF, 2'b00, 1'b1, 8'h14, 32'h11223344, 32'h00000000, 1'b1, 1'b0, 32'h00003000, 32'h00000000, 32'h00000022, 1'b0};
    vecs[5]  = '{32'h00003003, 32'h0000FFFF, 2'b01, 1'b1, 8'h15, 32'h11223344, 32'h00000000, 1'b1, 1'b0, 32'h00003000, 32'h00000000, 32'h00000011, 1'b0};
    vecs[6]  = '{32'h00004002, 32'h0000FFFF, 2'b10, 1'b1, 8'h16, 32'hCAFEBABE, 32'h00000000, 1'b1, 1'b0, 32'h00004000, 32'h00000000, 32'h0000CAFE, 1'b0};
    vecs[7]  = '{32'h00004001, 32'h0000FFFF, 2'b10, 1'b1, 8'h17, 32'h12345678, 32'h00000000, 1'b1, 1'b0, 32'h00004000, 32'h00000000, 32'h00003456, 1'b0};
    vecs[8]  = '{32'h00005001, 32'h0000FFFF, 2'b11, 1'b1, 8'h18, 32'h33221100, 32'h77665544, 1'b1, 1'b1, 32'h00005000, 32'h00005004, 32'h44332211, 1'b0};
    vecs[9]  = '{32'h00009000, 32'h00000000, 2'b11, 1'b0, 8'h19, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0};
    vecs[10] = '{32'h00006002, 32'h0000FFFF, 2'b11, 1'b1, 8'h1A, 32'hDDCCBBAA, 32'h44332211, 1'b1, 1'b1, 32'h00006000, 32'h00006004, 32'h2211DDCC, 1'b0};
    vecs[11] = '{32'h00007000, 32'h00007000, 2'b11, 1'b1, 8'h1B, 32'h87654321, 32'h00000000, 1'b1, 1'b0, 32'h00007000, 32'h00000000, 32'h87654321, 1'b0};

    idleInputs();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i], i);
    end

    // Backpressure: result held through five stalled cycles, consumed on release.
    bus.i_stall = 1'b1;
    startOp(32'h00001000, 2'b11, 32'h0000FFFF, 8'h22);
    bus.i_dc_ack  = 1'b1;
    bus.i_dc_data = 32'hDDCCBBAA;
    @(negedge clk);
    bus.i_dc_ack  = 1'b0;
    bus.i_dc_data = 32'd0;
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("bp%0d.v", i),     {31'd0, bus.o_v},     32'd1);
      checkOutput($sformatf("bp%0d.data", i),  bus.o_data,           32'hDDCCBBAA);
      checkOutput($sformatf("bp%0d.stall", i), {31'd0, bus.o_stall}, 32'd1);
      checkOutput($sformatf("bp%0d.tag", i),   {24'd0, bus.o_tag},   32'h22);
      if (i == 4) bus.i_stall = 1'b0;
      @(negedge clk);
    end
    checkOutput("bp.releasedV",     {31'd0, bus.o_v},     32'd0);
    checkOutput("bp.releasedStall", {31'd0, bus.o_stall}, 32'd0);

    // Flush in REQ0 with a 3-cycle ack delay: split still completes, no result.
    startOp(32'h00001003, 2'b11, 32'h0000FFFF, 8'h33);
    bus.i_flush = 1'b1;
    @(negedge clk);
    bus.i_flush = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("flush.req0Held", {31'd0, bus.o_dc_req}, 32'd1);
    checkOutput("flush.req0Addr", bus.o_dc_addr,         32'h00001000);
    bus.i_dc_ack  = 1'b1;
    bus.i_dc_data = 32'h44332211;
    @(negedge clk);
    checkOutput("flush.req1",     {31'd0, bus.o_dc_req}, 32'd1);
    checkOutput("flush.req1Addr", bus.o_dc_addr,         32'h00001004);
    checkOutput("flush.req1V",    {31'd0, bus.o_v},      32'd0);
    bus.i_dc_data = 32'h88776655;
    @(negedge clk);
    bus.i_dc_ack  = 1'b0;
    bus.i_dc_data = 32'd0;
    checkOutput("flush.endV",     {31'd0, bus.o_v},     32'd0);
    checkOutput("flush.endStall", {31'd0, bus.o_stall}, 32'd0);
    @(negedge clk);
    checkOutput("flush.laterV", {31'd0, bus.o_v}, 32'd0);

    // Reset while waiting in REQ1.
    startOp(32'h00001003, 2'b11, 32'h0000FFFF, 8'h44);
    bus.i_dc_ack  = 1'b1;
    bus.i_dc_data = 32'h44332211;
    @(negedge clk);
    bus.i_dc_ack  = 1'b0;
    checkOutput("rstReq1.addr", bus.o_dc_addr, 32'h00001004);
    rst = 1'b1;
    @(negedge clk);
    checkAllZero("rstReq1");
    rst = 1'b0;

    // Flush coincident with the first ack of a split op still issues REQ1.
    startOp(32'h00001003, 2'b11, 32'h0000FFFF, 8'h55);
    bus.i_flush   = 1'b1;
    bus.i_dc_ack  = 1'b1;
    bus.i_dc_data = 32'h44332211;
    @(negedge clk);
    bus.i_flush = 1'b0;
    checkOutput("flushAck.req1",     {31'd0, bus.o_dc_req}, 32'd1);
    checkOutput("flushAck.req1Addr", bus.o_dc_addr,         32'h00001004);
    bus.i_dc_data = 32'h88776655;
    @(negedge clk);
    bus.i_dc_ack  = 1'b0;
    bus.i_dc_data = 32'd0;
    checkOutput("flushAck.endV",     {31'd0, bus.o_v},     32'd0);
    checkOutput("flushAck.endStall", {31'd0, bus.o_stall}, 32'd0);

    // Flush in DONE drops the pending result despite downstream stall.
    bus.i_stall = 1'b1;
    startOp(32'h00002001, 2'b11, 32'h00002000, 8'h66);
    checkOutput("flushDone.v",     {31'd0, bus.o_v},     32'd1);
    checkOutput("flushDone.fault", {31'd0, bus.o_fault}, 32'd1);
    bus.i_flush = 1'b1;
    @(negedge clk);
    bus.i_flush = 1'b0;
    bus.i_stall = 1'b0;
    checkOutput("flushDone.afterV",     {31'd0, bus.o_v},     32'd0);
    checkOutput("flushDone.afterStall", {31'd0, bus.o_stall}, 32'd0);

    // Flush and valid together in IDLE: op is not accepted.
    @(negedge clk);
    bus.i_v         = 1'b1;
    bus.i_memRen    = 1'b1;
    bus.i_virt_addr = 32'h00001000;
    bus.i_seg_lim   = 32'h0000FFFF;
    bus.i_opSize    = 2'b11;
    bus.i_flush     = 1'b1;
    @(negedge clk);
    bus.i_v     = 1'b0;
    bus.i_flush = 1'b0;
    checkOutput("flushIdle.stall", {31'd0, bus.o_stall},  32'd0);
    checkOutput("flushIdle.req",   {31'd0, bus.o_dc_req}, 32'd0);
    checkOutput("flushIdle.v",     {31'd0, bus.o_v},      32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
